arbiter_wrr_n_ch: RTL and testbench
===================================

Name: arbiter_wrr_n_ch

Overview:
Parametrised weighted round-robin bus arbiter for NUM_CH masters. It is the N-channel successor of the existing 4-channel WRR arbiter.
- Per-channel programmable weights set how many grants each master may take per round.
- Credits reload automatically when eligible work is exhausted.
- New in this generation: grant index/valid outputs, a round-done pulse, and an optional hold-timeout watchdog.
- Sits between bus masters and the shared-bus mux; gnt_id drives the mux select.

Parameters:
NUM_CH, 4, number of requesting masters (2..16)
WT_W, 4, width of each weight/credit counter
ID_W, $clog2(NUM_CH), width of gnt_id (derived; not overridden)
TIMEOUT_CYC, 256, max cycles a grant may be held (used only with WRR_GNT_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_vec  in  NUM_CH  per-master bus request, level
req_wt  in  NUM_CH*WT_W  packed weights; channel i at [i*WT_W +: WT_W]
req_n_valid  in  1  single-cycle pulse: start new arbitration interval, latch weights
end_access_vec  in  NUM_CH  per-master bus release pulse
gnt_vec  out  NUM_CH  one-hot grant (all-zero = no grant)
gnt_valid  out  1  OR-reduction of gnt_vec
gnt_id  out  ID_W  index of the granted channel (0 when no grant)
round_done  out  1  one-cycle pulse when credits are reloaded
timeout_err  out  1  one-cycle pulse on forced revoke (tied 0 without the macro)

Behaviour:
- Reset state:
  - state=IDLE; gnt_vec=0, gnt_valid=0, gnt_id=0, round_done=0, timeout_err=0.
  - All credits=0, stored weights=0.
  - last_ptr=NUM_CH-1, so the first search starts at ch0.
- States: IDLE, ARM, BUSY. All outputs are registered.
- IDLE:
  - On req_n_valid: latch req_wt into stored weights and credits; go to ARM; gnt_vec=0.
  - Without req_n_valid, stay in IDLE.
- Eligibility: eligible[i] = req_vec[i] & (credit[i]!=0).
- Pick: first eligible channel searching from last_ptr+1 upward, modulo NUM_CH (wrap-around).
- ARM:
  - If any channel is eligible: register the one-hot grant for the picked channel, decrement its credit by 1, set last_ptr=picked, go to BUSY. Grant is visible 1 cycle after the decision cycle.
  - Else, if any req_vec bit is set (all requesters out of credit): reload credits from stored weights, pulse round_done, stay in ARM. Grant follows the next cycle at the earliest.
  - Else: stay in ARM with gnt_vec=0.
  - req_n_valid in ARM: re-latch weights and credits, round_done not pulsed, no grant that cycle.
- BUSY:
  - Grant is held regardless of req_vec until end_access_vec[gnt_id]=1.
  - On release: re-arbitrate in the same cycle using the ARM rules. The back-to-back grant is registered next cycle, so gnt_vec changes directly from old one-hot to new one-hot.
  - If nothing is eligible on release: gnt_vec=0, go to ARM (reload rule applies in the same cycle).
  - end_access_vec bits for non-granted channels are ignored.
  - req_n_valid in BUSY is ignored.
- Weight rules:
  - A channel with weight 0 is never granted.
  - Credit arithmetic is unsigned WT_W bits and never underflows, because decrement happens only when credit!=0.
- Reset asserted mid-grant: all outputs return to reset values on the next edge. No release is required.

Optional Feature:
Macro WRR_GNT_TIMEOUT_EN.
- Defined:
  - A hold counter of $clog2(TIMEOUT_CYC+1) bits clears on each new grant and increments every BUSY cycle.
  - At count==TIMEOUT_CYC-1 without a release, the grant is revoked exactly as if end_access had been asserted, and timeout_err pulses for one cycle.
  - The revoked channel's credit stays consumed.
- Undefined: no counter is built; timeout_err is tied to 0.

Decomposition:
- Package arbiter_wrr_pkg: state enum (IDLE/ARM/BUSY, one-hot encoding), a clog2 helper function, and the default constants for NUM_CH and WT_W.
- One sub-module: wrr_rr_pick, a purely combinational rotating-priority picker.
  - Inputs: eligible vector and last_ptr.
  - Outputs: found flag, picked index, one-hot vector.
- The FSM, credit counters and timeout logic stay in arbiter_wrr_n_ch.

Test Plan:
1. Basic weighting: NUM_CH=4, weights {1,2,3,0} (ch0..ch3), all req=1, req_n_valid pulse, end_access one cycle after each grant.
   - Required grant order: 0,1,2,1,2,2, then round_done, then 0,1,2,…
   - ch3 never granted.
2. Back-to-back handover: ch0 and ch1 requesting, ch0 granted; assert end_access_vec[0].
   - gnt_vec goes 0001→0010 on the next edge with no zero cycle.
3. Wrap-around: last_ptr=3, only ch1 requesting with credit.
   - gnt_id=1 on the next grant.
   - A late request on ch3 is served only after ch1 is released.
4. Ignored release and dropped request: ch2 granted; pulse end_access_vec[0]; deassert req_vec[2].
   - gnt_vec stays 0100 until end_access_vec[2].
5. Reset mid-grant: assert reset while gnt_vec=0010.
   - Next cycle: gnt_vec=0, gnt_id=0, state IDLE.
   - No grant until a new req_n_valid.
6. Timeout (macro on, TIMEOUT_CYC=8): grant ch1, never release.
   - Revoke after 8 BUSY cycles; timeout_err pulses once.
   - Next eligible channel is granted one cycle later.

Source files
------------

// File: rtl/arbiter_wrr_pkg.sv
// Shared definitions for the N-channel weighted round-robin arbiter:
// FSM state encoding, default sizing constants and a constant clog2 helper.
package arbiter_wrr_pkg;

   localparam int NUM_CH_DEF = 4;
   localparam int WT_W_DEF   = 4;

   // One-hot state encoding so a single bit identifies each state on debug taps.
   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_ARM  = 3'b010,
      ST_BUSY = 3'b100
   } arb_state_e;

   // Ceiling log2 usable in parameter expressions.
   function automatic int clog2_f(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res++;
      return res;
   endfunction

endpackage

// File: rtl/wrr_rr_pick.sv
// Rotating-priority picker: finds the first eligible channel strictly after
// last_ptr_i, wrapping modulo NUM_CH. Purely combinational.
module wrr_rr_pick #(
   parameter int NUM_CH = 4,
   parameter int ID_W   = 2
) (
   input  logic [NUM_CH-1:0] eligible_i,
   input  logic [ID_W-1:0]   last_ptr_i,
   output logic              found_o,
   output logic [ID_W-1:0]   pick_idx_o,
   output logic [NUM_CH-1:0] pick_oh_o
);

   // Walk the channels from last_ptr+1 around to last_ptr itself; first hit wins.
   always_comb begin
      int idx;
      idx        = 0;
      found_o    = 1'b0;
      pick_idx_o = '0;
      pick_oh_o  = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = (int'(last_ptr_i) + k) % NUM_CH;
         if (!found_o && eligible_i[idx]) begin
            found_o        = 1'b1;
            pick_idx_o     = ID_W'(idx);
            pick_oh_o[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arbiter_wrr_n_ch.sv
// Weighted round-robin bus arbiter for NUM_CH masters.
// Optional hold-timeout watchdog enabled by defining WRR_GNT_TIMEOUT_EN.
//
// Handshake: a master holds req_vec[i] high while it wants the bus. Once
// granted (gnt_vec one-hot, gnt_id = index) the grant is kept regardless of
// req_vec until end_access_vec[gnt_id] is seen high on a rising edge; release
// pulses from non-granted channels are ignored. req_n_valid is a one-cycle
// pulse accepted only in IDLE/ARM that latches req_wt as weights and credits.
module arbiter_wrr_n_ch
   import arbiter_wrr_pkg::*;
#(
   parameter int  NUM_CH      = NUM_CH_DEF,
   parameter int  WT_W        = WT_W_DEF,
   parameter int  TIMEOUT_CYC = 256,
   localparam int ID_W        = clog2_f(NUM_CH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_CH-1:0]      req_vec,
   input  logic [NUM_CH*WT_W-1:0] req_wt,
   input  logic                   req_n_valid,
   input  logic [NUM_CH-1:0]      end_access_vec,
   output logic [NUM_CH-1:0]      gnt_vec,
   output logic                   gnt_valid,
   output logic [ID_W-1:0]        gnt_id,
   output logic                   round_done,
   output logic                   timeout_err,
   output logic [2:0]             dbg_state
);

   arb_state_e                    state_q, state_d;
   logic [NUM_CH-1:0][WT_W-1:0]   wt_q, wt_d;
   logic [NUM_CH-1:0][WT_W-1:0]   credit_q, credit_d;
   logic [ID_W-1:0]               last_ptr_q, last_ptr_d;
   logic [NUM_CH-1:0]             gnt_vec_q, gnt_vec_d;
   logic                          gnt_valid_q, gnt_valid_d;
   logic [ID_W-1:0]               gnt_id_q, gnt_id_d;
   logic                          round_done_q, round_done_d;

   logic [NUM_CH-1:0]             eligible;
   logic                          found;
   logic [ID_W-1:0]               pick_idx;
   logic [NUM_CH-1:0]             pick_oh;
   logic                          release_hit;
   logic                          timeout_hit;
   logic                          do_arb;

   // A channel competes only while requesting and holding at least one credit.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         eligible[i] = req_vec[i] && (credit_q[i] != '0);
      end
   end

   wrr_rr_pick #(
      .NUM_CH (NUM_CH),
      .ID_W   (ID_W)
   ) u_pick (
      .eligible_i (eligible),
      .last_ptr_i (last_ptr_q),
      .found_o    (found),
      .pick_idx_o (pick_idx),
      .pick_oh_o  (pick_oh)
   );

   // Only the current grantee's release bit matters.
   assign release_hit = (state_q == ST_BUSY) && end_access_vec[gnt_id_q];

`ifdef WRR_GNT_TIMEOUT_EN
   localparam int HOLD_W = clog2_f(TIMEOUT_CYC + 1);

   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              timeout_err_q;

   assign timeout_hit = (state_q == ST_BUSY) && !release_hit &&
                        (hold_cnt_q == HOLD_W'(TIMEOUT_CYC - 1));

   // Count BUSY cycles of the current grant; any (re)arbitration restarts it.
   always_comb begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      if (state_q != ST_BUSY || release_hit || timeout_hit) hold_cnt_d = '0;
   end

   // Hold counter and one-cycle forced-revoke flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         hold_cnt_q    <= hold_cnt_d;
         timeout_err_q <= timeout_hit;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Next-state, credit bookkeeping and registered-output decisions.
   always_comb begin
      state_d      = state_q;
      wt_d         = wt_q;
      credit_d     = credit_q;
      last_ptr_d   = last_ptr_q;
      gnt_vec_d    = gnt_vec_q;
      gnt_id_d     = gnt_id_q;
      round_done_d = 1'b0;
      do_arb       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            gnt_vec_d = '0;
            gnt_id_d  = '0;
            if (req_n_valid) begin
               wt_d     = req_wt;
               credit_d = req_wt;
               state_d  = ST_ARM;
            end
         end
         ST_ARM: begin
            gnt_vec_d = '0;
            gnt_id_d  = '0;
            if (req_n_valid) begin
               wt_d     = req_wt;
               credit_d = req_wt;
            end else begin
               do_arb = 1'b1;
            end
         end
         ST_BUSY: begin
            // A forced revoke is handled exactly like a release.
            if (release_hit || timeout_hit) do_arb = 1'b1;
         end
         default: begin
            state_d   = ST_IDLE;
            gnt_vec_d = '0;
            gnt_id_d  = '0;
         end
      endcase

      if (do_arb) begin
         if (found) begin
            gnt_vec_d          = pick_oh;
            gnt_id_d           = pick_idx;
            credit_d[pick_idx] = credit_q[pick_idx] - WT_W'(1);
            last_ptr_d         = pick_idx;
            state_d            = ST_BUSY;
         end else begin
            gnt_vec_d = '0;
            gnt_id_d  = '0;
            state_d   = ST_ARM;
            // Requesters exist but all are out of credit: start a new round.
            if (|req_vec) begin
               credit_d     = wt_q;
               round_done_d = 1'b1;
            end
         end
      end

      gnt_valid_d = |gnt_vec_d;
   end

   // State, weights, credits and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         wt_q         <= '0;
         credit_q     <= '0;
         last_ptr_q   <= ID_W'(NUM_CH - 1);
         gnt_vec_q    <= '0;
         gnt_valid_q  <= 1'b0;
         gnt_id_q     <= '0;
         round_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wt_q         <= wt_d;
         credit_q     <= credit_d;
         last_ptr_q   <= last_ptr_d;
         gnt_vec_q    <= gnt_vec_d;
         gnt_valid_q  <= gnt_valid_d;
         gnt_id_q     <= gnt_id_d;
         round_done_q <= round_done_d;
      end
   end

   assign gnt_vec    = gnt_vec_q;
   assign gnt_valid  = gnt_valid_q;
   assign gnt_id     = gnt_id_q;
   assign round_done = round_done_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_arbiter_wrr_n_ch.sv
// Directed bench for arbiter_wrr_n_ch (NUM_CH=4, WT_W=4, TIMEOUT_CYC=8).
// Grant-order expectations go into exp_q; a negedge monitor pops them.
module tb_arbiter_wrr_n_ch;
   import arbiter_wrr_pkg::*;

   localparam int NUM_CH = 4;
   localparam int WT_W   = 4;
   localparam int ID_W   = 2;
   localparam int TO_CYC = 8;

   // ---------------- clock / reset ----------------
   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic [NUM_CH-1:0]      req_vec = '0;
   logic [NUM_CH*WT_W-1:0] req_wt = '0;
   logic                   req_n_valid = 1'b0;
   logic [NUM_CH-1:0]      end_access_vec = '0;
   logic [NUM_CH-1:0]      gnt_vec;
   logic                   gnt_valid;
   logic [ID_W-1:0]        gnt_id;
   logic                   round_done;
   logic                   timeout_err;
   logic [2:0]             dbg_state;

   always #5 clk = ~clk;

   arbiter_wrr_n_ch #(
      .NUM_CH      (NUM_CH),
      .WT_W        (WT_W),
      .TIMEOUT_CYC (TO_CYC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req_vec        (req_vec),
      .req_wt         (req_wt),
      .req_n_valid    (req_n_valid),
      .end_access_vec (end_access_vec),
      .gnt_vec        (gnt_vec),
      .gnt_valid      (gnt_valid),
      .gnt_id         (gnt_id),
      .round_done     (round_done),
      .timeout_err    (timeout_err),
      .dbg_state      (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [ID_W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int rd_cnt = 0;
   int to_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: a new grant is one that appears from no-grant, or follows a
   // release / forced revoke of the previous grantee. Otherwise it must hold.
   logic              prev_valid = 1'b0;
   logic [NUM_CH-1:0] prev_vec = '0;
   logic              rel_pending = 1'b0;
   logic              prev_rst = 1'b1;
   logic [ID_W-1:0]   exp_id;

   always @(negedge clk) begin
      if (round_done) rd_cnt++;
      if (timeout_err) to_cnt++;
      check("gnt_valid_or", {31'd0, gnt_valid}, {31'd0, |gnt_vec});
      if (!prev_rst) begin
         if (gnt_valid && (!prev_valid || rel_pending || timeout_err)) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_grant: got ch%0d expected none", gnt_id);
            end else begin
               exp_id = exp_q.pop_front();
               check("grant_id", {30'd0, gnt_id}, {30'd0, exp_id});
               check("grant_vec", {28'd0, gnt_vec}, 32'd1 << exp_id);
            end
         end else if (prev_valid && !rel_pending && !timeout_err) begin
            check("grant_hold", {28'd0, gnt_vec}, {28'd0, prev_vec});
         end
      end
      prev_valid  = gnt_valid;
      prev_vec    = gnt_vec;
      rel_pending = gnt_valid && end_access_vec[gnt_id];
      prev_rst    = reset;
   end

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      req_vec = '0;
      end_access_vec = '0;
      req_n_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic pulse_start(input logic [15:0] wt);
      req_wt = wt;
      @(posedge clk); #1;
      req_n_valid = 1'b1;
      @(posedge clk); #1;
      req_n_valid = 1'b0;
   endtask

   task automatic wait_grant();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (gnt_valid) seen = 1'b1;
      end
      if (!seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_grant: got no grant in 20 cycles expected a grant");
      end
   endtask

   task automatic serve(input int ch);
      logic [NUM_CH-1:0] oh;
      oh = '0;
      oh[ch] = 1'b1;
      wait_grant();
      @(posedge clk); #1;
      end_access_vec = oh;
      @(posedge clk); #1;
      end_access_vec = '0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_gnt_vec", {28'd0, gnt_vec}, 32'd0);
      check("rst_gnt_id", {30'd0, gnt_id}, 32'd0);
      check("rst_gnt_valid", {31'd0, gnt_valid}, 32'd0);
      check("rst_round_done", {31'd0, round_done}, 32'd0);
      check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
      check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      @(posedge clk); #1;
      reset = 1'b0;

      // 1: weights ch0..ch3 = 1,2,3,0, everyone requesting
      req_vec = 4'b1111;
      exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
      exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd2);
      pulse_start(16'h0321);
      serve(0); serve(1); serve(2); serve(1); serve(2); serve(2);
      @(negedge clk);
      check("round_done_pulse", {31'd0, round_done}, 32'd1);
      check("round_gap_no_grant", {31'd0, gnt_valid}, 32'd0);
      exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
      serve(0); serve(1);
      req_vec = 4'b0000;
      serve(2);

      // 2: back-to-back handover ch0 -> ch1 with no idle cycle
      apply_reset();
      req_vec = 4'b0011;
      exp_q.push_back(2'd0); exp_q.push_back(2'd1);
      pulse_start(16'h1111);
      serve(0);
      @(negedge clk);
      check("b2b_vec", {28'd0, gnt_vec}, 32'h2);
      req_vec = 4'b0000;
      serve(1);

      // 3: wrap-around from last_ptr=3, late ch3 request waits for release
      apply_reset();
      req_vec = 4'b1000;
      exp_q.push_back(2'd3);
      pulse_start(16'h2010);
      wait_grant();
      req_vec = 4'b0010;
      exp_q.push_back(2'd1);
      serve(3);
      @(negedge clk);
      check("wrap_id", {30'd0, gnt_id}, 32'd1);
      req_vec = 4'b1010;
      repeat (3) begin
         @(negedge clk);
         check("late_req_hold", {28'd0, gnt_vec}, 32'h2);
      end
      exp_q.push_back(2'd3);
      serve(1);
      req_vec = 4'b0000;
      serve(3);

      // 4: foreign release and dropped request do not end the grant
      apply_reset();
      req_vec = 4'b0100;
      exp_q.push_back(2'd2);
      pulse_start(16'h0100);
      wait_grant();
      @(posedge clk); #1;
      end_access_vec = 4'b0001;
      req_vec = 4'b0000;
      @(posedge clk); #1;
      end_access_vec = 4'b0000;
      repeat (2) begin
         @(negedge clk);
         check("ignored_release", {28'd0, gnt_vec}, 32'h4);
      end
      serve(2);
      @(negedge clk);
      check("after_release", {28'd0, gnt_vec}, 32'h0);

      // 5: reset while ch1 is granted
      apply_reset();
      req_vec = 4'b0010;
      exp_q.push_back(2'd1);
      pulse_start(16'h0010);
      wait_grant();
      check("pre_reset_vec", {28'd0, gnt_vec}, 32'h2);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_gnt_vec", {28'd0, gnt_vec}, 32'h0);
      check("midrst_gnt_id", {30'd0, gnt_id}, 32'd0);
      check("midrst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      repeat (5) begin
         @(negedge clk);
         check("no_grant_wo_start", {31'd0, gnt_valid}, 32'd0);
      end
      req_vec = 4'b0000;

      // 6: hold-timeout watchdog
      apply_reset();
      req_vec = 4'b0110;
      exp_q.push_back(2'd1);
`ifdef WRR_GNT_TIMEOUT_EN
      exp_q.push_back(2'd2);
`endif
      pulse_start(16'h0110);
      wait_grant();
`ifdef WRR_GNT_TIMEOUT_EN
      for (int i = 1; i < TO_CYC; i++) begin
         @(negedge clk);
         check("to_quiet", {31'd0, timeout_err}, 32'd0);
      end
      @(negedge clk);
      check("to_pulse", {31'd0, timeout_err}, 32'd1);
      check("to_next_grant", {30'd0, gnt_id}, 32'd2);
      @(negedge clk);
      check("to_pulse_once", {31'd0, timeout_err}, 32'd0);
      apply_reset();
`else
      for (int i = 0; i < TO_CYC + 4; i++) begin
         @(negedge clk);
         check("long_hold_vec", {28'd0, gnt_vec}, 32'h2);
         check("no_timeout", {31'd0, timeout_err}, 32'd0);
      end
      req_vec = 4'b0000;
      serve(1);
`endif

      // Final report
      repeat (3) @(negedge clk);
      check("exp_q_drained", exp_q.size(), 32'd0);
      check("round_done_total", rd_cnt, 32'd1);
`ifdef WRR_GNT_TIMEOUT_EN
      check("timeout_total", to_cnt, 32'd1);
`else
      check("timeout_total", to_cnt, 32'd0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
